// File: rtl/calc_pkg.sv
// Shared constants and types for the calc neuron aggregator.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block).
package calc_pkg;

   localparam int unsigned CALC_ALU_WIDTH = 12;
   localparam int unsigned CALC_N_INPUTS  = 784;
   localparam int unsigned CALC_THRESHOLD = CALC_N_INPUTS / 2;

   typedef logic [CALC_ALU_WIDTH-1:0] calc_acc_t;

endpackage

// File: rtl/calc_sign_act.sv
// Sign-style binary activation: fires when the mismatch count is at or below THRESHOLD.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows acc continuously.
module calc_sign_act #(
   parameter int unsigned WIDTH     = 12,
   parameter int unsigned THRESHOLD = 392
) (
   input  logic [WIDTH-1:0] acc,
   output logic             acted
);

   // Compare at 32 bits so a THRESHOLD wider than acc is handled without truncation.
   always_comb begin
      acted = (32'(acc) <= THRESHOLD);
   end

endmodule

// File: rtl/calc.sv
// BNN neuron aggregator: counts XOR mismatch bits and exposes count plus binary activation.
// Latency: an input sampled at edge k is visible right after edge k (1 clock).
// Backpressure: none; accumulates every cycle calc_1 is high. Macro CALC_SAT_EN selects saturation over wrap.
module calc
   import calc_pkg::*;
#(
   parameter int unsigned alu_width = CALC_ALU_WIDTH,
   parameter int unsigned N_INPUTS  = CALC_N_INPUTS,
   parameter int unsigned THRESHOLD = N_INPUTS / 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 calc_1,
   input  logic                 calc_in,
   output logic [alu_width-1:0] agg_out2alu,
   output logic                 agg_out_acted
);

   logic [alu_width-1:0] acc;
   logic [alu_width-1:0] acc_inc;

   // Product bit zero-extended to accumulator width.
   always_comb begin
      acc_inc = {{(alu_width-1){1'b0}}, calc_in};
   end

   // Accumulator: reset beats enable, so a product arriving with rst is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (calc_1) begin
`ifdef CALC_SAT_EN
         // Hold at full scale instead of wrapping back to a small count.
         if (acc != '1) begin
            acc <= acc + acc_inc;
         end
`else
         acc <= acc + acc_inc;
`endif
      end
   end

   assign agg_out2alu = acc;

   calc_sign_act #(
      .WIDTH     (alu_width),
      .THRESHOLD (THRESHOLD)
   ) u_sign_act (
      .acc   (acc),
      .acted (agg_out_acted)
   );

endmodule

// File: tb/tb_calc.sv
// Self-checking bench for calc: default instance plus a 4-bit instance for overflow behaviour.
// Latency: checks each cycle one clock after stimulus.
// Backpressure: n/a.
module tb_calc;
   import calc_pkg::*;

   localparam int SW   = 4;
   localparam int STHR = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           calc_1 = 1'b0;
   logic           calc_in = 1'b0;
   calc_acc_t      agg_out2alu;
   logic           agg_out_acted;
   logic [SW-1:0]  s_out2alu;
   logic           s_out_acted;

   always #5 clk = ~clk;

   calc dut (
      .clk           (clk),
      .rst           (rst),
      .calc_1        (calc_1),
      .calc_in       (calc_in),
      .agg_out2alu   (agg_out2alu),
      .agg_out_acted (agg_out_acted)
   );

   calc #(.alu_width(SW), .THRESHOLD(STHR)) dut_s (
      .clk           (clk),
      .rst           (rst),
      .calc_1        (calc_1),
      .calc_in       (calc_in),
      .agg_out2alu   (s_out2alu),
      .agg_out_acted (s_out_acted)
   );

   typedef struct {
      int   cnt;
      logic act;
      int   scnt;
      logic sact;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_cnt  = 0;
   int   m_scnt = 0;

   task automatic cmp(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
      end
   endtask

   // Reference: a counter of mismatches, wrapped or clamped at the width limit.
   function automatic int next_cnt(input int cur, input int w, input bit r, input bit en, input bit b);
      int lim;
      int n;
      lim = (1 << w);
      if (r) return 0;
      if (!en) return cur;
      n = cur + int'(b);
`ifdef CALC_SAT_EN
      if (n > lim - 1) n = lim - 1;
`else
      n = n % lim;
`endif
      return n;
   endfunction

   task automatic step(input bit r, input bit en, input bit b);
      exp_t e;
      @(negedge clk);
      rst     = r;
      calc_1  = en;
      calc_in = b;
      m_cnt   = next_cnt(m_cnt, CALC_ALU_WIDTH, r, en, b);
      m_scnt  = next_cnt(m_scnt, SW, r, en, b);
      e.cnt   = m_cnt;
      e.act   = (m_cnt <= int'(CALC_THRESHOLD));
      e.scnt  = m_scnt;
      e.sact  = (m_scnt <= STHR);
      q.push_back(e);
   endtask

   // Directed check of DUT state right after the edge that consumed the last step.
   task automatic chk(input string name, input int want_cnt, input bit want_act);
      @(posedge clk);
      #2;
      cmp({name, "_cnt"}, int'(agg_out2alu), want_cnt);
      cmp({name, "_act"}, int'(agg_out_acted), int'(want_act));
   endtask

   // 784 enabled cycles with exactly k ones at random positions.
   task automatic run_ones(input int k);
      bit arr[784];
      bit t;
      int j;
      for (int i = 0; i < 784; i++) arr[i] = (i < k);
      for (int i = 783; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = arr[i]; arr[i] = arr[j]; arr[j] = t;
      end
      for (int i = 0; i < 784; i++) step(1'b0, 1'b1, arr[i]);
   endtask

   // Monitor: one expected entry per clock edge, compared shortly after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp("sb_cnt",  int'(agg_out2alu), e.cnt);
            cmp("sb_act",  int'(agg_out_acted), int'(e.act));
            cmp("sb_scnt", int'(s_out2alu), e.scnt);
            cmp("sb_sact", int'(s_out_acted), int'(e.sact));
         end
      end
   end

   initial begin
      int budget;
      // Reset with enable and product high: product must be ignored.
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("reset", 0, 1'b1);

      run_ones(300);
      chk("count300", 300, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run_ones(500);
      chk("count500", 500, 1'b0);

      // Threshold boundary.
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 392; i++) step(1'b0, 1'b1, 1'b1);
      chk("thr392", 392, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("thr393", 393, 1'b0);

      // Enable gating.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
      chk("gate_en0", 393, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
      chk("gate_in0", 393, 1'b0);

      // Mid-run reset discards the partial sum.
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1);
      chk("mid100", 100, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("mid_rst", 0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
      chk("mid5", 5, 1'b1);

      // Overflow on the 4-bit instance.
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #2;
`ifdef CALC_SAT_EN
      cmp("ovf_small", int'(s_out2alu), 15);
`else
      cmp("ovf_small", int'(s_out2alu), 1);
`endif

      // Random traffic with occasional resets.
      for (int i = 0; i < 2000; i++)
         step(($urandom_range(49, 0) == 0), $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);

      // Held reset keeps the count at zero.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
      chk("rst_hold", 0, 1'b1);

      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #3;
      if (q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
